// File: rtl/occupancy_counter.sv
// occupancy_counter
// Car-park occupancy tracker. Turns the entry/exit detection strobes into
// single events, keeps a car count saturated between 0 and CAPACITY, and
// reports free spaces, full/empty status and sticky over/underflow flags.
module occupancy_counter #(
  parameter int CAPACITY = 15,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_in,
  input  logic          car_out,
  input  logic          clr_err,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free,
  output logic          full,
  output logic          empty,
  output logic          err_over,
  output logic          err_under
);

  // Capacity expressed at the count width so all compares and the
  // subtraction for free stay CW bits wide and unsigned.
  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  // Previous-cycle copies of the strobes, used for rising-edge detection.
  logic in_d;
  logic out_d;

  // One-cycle events: a strobe held high for several cycles counts once.
  logic ev_in;
  logic ev_out;

  // Saturation decodes of the current registered count.
  logic at_cap;
  logic at_zero;

  // Next-state values for the count and the two sticky flags.
  logic [CW-1:0] count_next;
  logic          err_over_next;
  logic          err_under_next;

  // Error events raised this cycle; they take priority over clr_err.
  logic over_event;
  logic under_event;

  assign ev_in   = car_in  & ~in_d;
  assign ev_out  = car_out & ~out_d;
  assign at_cap  = (count == CAP);
  assign at_zero = (count == '0);

  // Register the raw strobes so the next cycle can see their previous level.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_d  <= 1'b0;
      out_d <= 1'b0;
    end else begin
      in_d  <= car_in;
      out_d <= car_out;
    end
  end

  // Decide the next count: simultaneous entry and exit cancel out, otherwise
  // step up or down unless already pinned at a bound, in which case hold.
  always_comb begin
    count_next  = count;
    over_event  = 1'b0;
    under_event = 1'b0;
    unique case ({ev_in, ev_out})
      2'b10: begin
        if (at_cap) begin
          over_event = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end
      2'b01: begin
        if (at_zero) begin
          under_event = 1'b1;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: begin
        count_next = count;
      end
    endcase
  end

  // Sticky flag update: a fresh error wins over a same-cycle clear.
  always_comb begin
    err_over_next  = err_over;
    err_under_next = err_under;
    if (clr_err) begin
      err_over_next  = 1'b0;
      err_under_next = 1'b0;
    end
    if (over_event) begin
      err_over_next = 1'b1;
    end
    if (under_event) begin
      err_under_next = 1'b1;
    end
  end

  // Count and error-flag registers; reset discards any pending event.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else begin
      count     <= count_next;
      err_over  <= err_over_next;
      err_under <= err_under_next;
    end
  end

  // Status outputs are pure decodes of the registered count, so they
  // always agree with count in the same cycle.
  always_comb begin
    free  = CAP - count;
    full  = at_cap;
    empty = at_zero;
  end

endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter
// Directed bench for occupancy_counter with CAPACITY=15, CW=4. Expected
// values are written out by hand alongside each step.
module tb_occupancy_counter;

  localparam int CAPACITY = 15;
  localparam int CW       = 4;

  logic          clk;
  logic          reset;
  logic          car_in;
  logic          car_out;
  logic          clr_err;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          full;
  logic          empty;
  logic          err_over;
  logic          err_under;

  int vectors;
  int miscompares;

  occupancy_counter #(
    .CAPACITY(CAPACITY),
    .CW      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .car_in   (car_in),
    .car_out  (car_out),
    .clr_err  (clr_err),
    .count    (count),
    .free     (free),
    .full     (full),
    .empty    (empty),
    .err_over (err_over),
    .err_under(err_under)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then wait past the next rising edge so the
  // outputs are sampled 1 ns after the edge that consumed them.
  task automatic applyStimulus(input logic rst, input logic cin, input logic cout,
                               input logic clr);
    reset   = rst;
    car_in  = cin;
    car_out = cout;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected count and flags.
  task automatic checkOutput(input string tag, input int exp_count,
                             input logic exp_over, input logic exp_under);
    logic [CW-1:0] ec;
    logic [CW-1:0] ef;
    logic          efull;
    logic          eempty;
    ec     = exp_count[CW-1:0];
    ef     = 4'(CAPACITY - exp_count);
    efull  = (exp_count == CAPACITY);
    eempty = (exp_count == 0);

    vectors++;
    assert (count === ec) else begin
      miscompares++;
      $error("[TB] FAIL %s count: observed %0d expected %0d", tag, count, ec);
    end
    vectors++;
    assert (free === ef) else begin
      miscompares++;
      $error("[TB] FAIL %s free: observed %0d expected %0d", tag, free, ef);
    end
    vectors++;
    assert ({full, empty} === {efull, eempty}) else begin
      miscompares++;
      $error("[TB] FAIL %s full/empty: observed %b%b expected %b%b",
             tag, full, empty, efull, eempty);
    end
    vectors++;
    assert ({err_over, err_under} === {exp_over, exp_under}) else begin
      miscompares++;
      $error("[TB] FAIL %s err_over/err_under: observed %b%b expected %b%b",
             tag, err_over, err_under, exp_over, exp_under);
    end
  endtask

  // Linear directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    car_in  = 1'b0;
    car_out = 1'b0;
    clr_err = 1'b0;

    // Reset for two cycles, then idle.
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset_1", 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_idle", 0, 0, 0);

    // Fill to capacity with single-cycle entry pulses.
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput($sformatf("fill_%0d", i), i, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end

    // Sixteenth entry overflows: count held, err_over set.
    applyStimulus(0, 1, 0, 0);
    checkOutput("overflow", 15, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("overflow_sticky", 15, 1, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clr_over", 15, 0, 0);

    // Simultaneous entry and exit at full: no change, no error.
    applyStimulus(0, 1, 1, 0);
    checkOutput("simul_full", 15, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Drain to empty with exit pulses.
    for (int i = 14; i >= 0; i--) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("drain_%0d", i), i, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end

    // Simultaneous entry and exit at empty: no change, no error.
    applyStimulus(0, 1, 1, 0);
    checkOutput("simul_empty", 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Underflow sets err_under; clear coinciding with a new underflow keeps it.
    applyStimulus(0, 0, 1, 0);
    checkOutput("underflow", 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("set_wins", 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clr_under", 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Bring count to 3, then hold car_in high for 5 cycles: one entry only.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("count_3", 3, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("held_edge", 4, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(0, 1, 0, 0);
    end
    checkOutput("held_5", 4, 0, 0);

    // Pattern 1,0,1 after returning low: two entries.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pat_first", 5, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pat_gap", 5, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pat_second", 6, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Reach count 7 with err_over set: fill from 6 to 15, overflow, drain 8.
    for (int i = 7; i <= 15; i++) begin
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("pre_reset", 7, 1, 0);

    // Reset together with a car_in edge: everything cleared, no increment.
    applyStimulus(1, 1, 0, 0);
    checkOutput("reset_mid", 0, 0, 0);

    // Strobe still high in the first cycle after reset counts as an entry.
    applyStimulus(0, 1, 0, 0);
    checkOutput("post_reset_strobe", 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("post_reset_idle", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
